cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Miss handler beside the direct-mapped cache. It turns a cache Miss into an 8-word block fill from main memory.
//  Issues 8 pipelined reads, one per cycle, and streams returned words into the cache data array.
//  Drives the data-array write strobe and word number, then writes the tag/valid entry with the last word.
//  Holds the pipeline stalled (fsm_busy) for the whole fill.
// PARAMETERS
//  ADDR_W      16  byte-address width
//  DATA_W      16  word width
//  BLK_WORDS    8  words per cache block (power of 2; word index = log2(BLK_WORDS) = 3 bits)
// PORTS
//  clk                 in   1       clock, all state updates on rising edge
//  rst                 in   1       asynchronous, active-low reset
//  miss_detected       in   1       cache Miss, qualified by a read/write request
//  miss_address        in   ADDR_W  byte address that missed
//  memory_data         in   DATA_W  read data returned by main memory
//  memory_data_valid   in   1       memory_data valid this cycle (in-order returns)
//  memory_address      out  ADDR_W  read address to main memory
//  memory_read_en      out  1       read request this cycle
//  fill_data           out  DATA_W  word to cache Data_In (= memory_data)
//  write_data_array    out  1       cache data-array write strobe
//  word_num            out  3       word-in-block being written (cache Word_Num)
//  write_tag_array     out  1       cache tag/valid write strobe
//  fsm_busy            out  1       fill in progress; upstream stalls
//  fill_done           out  1       one-cycle pulse, fill complete
// BEHAVIOUR
//  Reset (rst==0, async)
//   - state=IDLE, req_cnt=0, rsp_cnt=0, base=0.
//   - All outputs 0; write_* are never asserted while in reset.
//  States
//   - IDLE: fsm_busy=0, memory_read_en=0.
//     - If miss_detected: latch base={miss_address[15:4],4'h0}, clear counters, next=FILL.
//   - FILL: fsm_busy=1.
//     - Requests: memory_read_en=1 while req_cnt<8; memory_address=base+{req_cnt,1'b0}; req_cnt++ each request cycle.
//     - Returns: on memory_data_valid, write_data_array=1, word_num=rsp_cnt[2:0], fill_data=memory_data, all combinational in the same cycle; rsp_cnt++.
//     - When memory_data_valid && rsp_cnt==7: write_tag_array=1 in the same cycle, next=IDLE, fill_done=1 next cycle.
//  Counters
//   - req_cnt and rsp_cnt are 4 bits; they saturate at 8 and never wrap.
//   - memory_address uses ADDR_W-bit modular addition; base is 16-byte aligned, so no carry out of the block.
//  Outputs
//   - write_data_array, word_num, fill_data, memory_address, memory_read_en and write_tag_array are combinational from state, counters and inputs.
//   - fsm_busy and fill_done are registered.
//   - word_num=0 and memory_address=0 whenever their strobes are low.
//  Edge cases
//   - memory_data_valid in IDLE: ignored, no writes.
//   - miss_detected while in FILL: ignored; miss_address is not re-latched.
//   - A request and a return in the same cycle: both are handled, counters advance independently.
//   - Returns may arrive while requests are still issuing, with any memory latency >=1 cycle.
//   - Reset mid-fill: immediate IDLE. The partial block stays in the data array with its tag not written, so the line stays invalid or stale. A later miss refetches it.
//   - miss_detected in the cycle IDLE is re-entered: accepted, new fill starts.
//  Latency (memory latency L)
//   - Miss sampled at edge 0. Requests in cycles 1..8. Writes in cycles 1+L..8+L.
//   - IDLE and fill_done in cycle 9+L; with L=4, fill_done in cycle 13.
// TESTING
//  1 Reset: rst=0 mid-stream with memory_data_valid=1 -> all outputs 0, no write strobes; after release, state IDLE.
//  2 Basic fill, L=4, miss_address=16'h1236 -> memory_address 1230,1232..123E in cycles 1-8; writes word_num 0..7 with data D0..D7 in cycles 5-12; write_tag_array only in cycle 12; fill_done in cycle 13.
//  3 Stall/ignore: miss_detected pulsed again in cycle 3 with 16'hBEEF -> addresses stay 1230..123E, single fill.
//  4 Irregular returns: memory_data_valid with gaps (e.g. 1,0,0,1,...) -> word_num follows the return order 0..7; tag write coincides with the 8th valid.
//  5 Reset at cycle 7 of a fill -> write_tag_array never asserted, fsm_busy=0; a new miss at 16'hFFF2 -> addresses FFF0..FFFE, no carry outside the block.
//  6 Back-to-back misses: miss_detected high in the cycle after fill_done -> second fill starts, base re-latched.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss-handler bus between cache, fill FSM and main memory
// Signals:
//   miss_detected, miss_address        cache -> fsm   miss request and byte address
//   memory_data, memory_data_valid     memory -> fsm  in-order read returns
//   memory_address, memory_read_en     fsm -> memory  pipelined read requests
//   fill_data, write_data_array,       fsm -> cache   data-array write port
//   word_num
//   write_tag_array                    fsm -> cache   tag/valid write strobe
//   fsm_busy, fill_done                fsm -> cache   stall and completion pulse
// Modports: master = the fill FSM, slave = the cache/memory side.
interface cache_fill_fsm_if #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
);
    localparam int WN_W = $clog2(BLK_WORDS);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_read_en;
    logic [DATA_W-1:0] fill_data;
    logic              write_data_array;
    logic [WN_W-1:0]   word_num;
    logic              write_tag_array;
    logic              fsm_busy;
    logic              fill_done;
    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output memory_address, memory_read_en, fill_data, write_data_array,
               word_num, write_tag_array, fsm_busy, fill_done
    );
    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  memory_address, memory_read_en, fill_data, write_data_array,
               word_num, write_tag_array, fsm_busy, fill_done
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: turns a cache miss into a pipelined block fill from main memory
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cache_fill_fsm_if.master (miss in, memory read port, cache write port, status)
// Requests issue one per cycle while returns are written as they arrive; the two
// counters advance independently and saturate at BLK_WORDS. The tag is written
// together with the last returned word.
module cache_fill_fsm #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input logic            clk,
    input logic            rst_n,
    cache_fill_fsm_if.master bus
);
    localparam int WN_W    = $clog2(BLK_WORDS);
    localparam int CW      = WN_W + 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = WN_W + BYTE_SH;
    localparam logic [ADDR_W-1:0] OFF_MASK = (ADDR_W'(1) << OFF_W) - ADDR_W'(1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    logic [CW-1:0]     req_cnt;
    logic [CW-1:0]     rsp_cnt;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              done;
    logic              req;
    logic              wr;
    logic              last;

    // Top counter bit set means all BLK_WORDS have been requested/returned.
    always_comb begin
        req  = (state == FILL) && !req_cnt[WN_W];
        wr   = (state == FILL) && bus.memory_data_valid && !rsp_cnt[WN_W];
        last = wr && (rsp_cnt[WN_W-1:0] == '1);
    end

    assign bus.memory_read_en   = req;
    assign bus.memory_address   = req ? base + (ADDR_W'(req_cnt[WN_W-1:0]) << BYTE_SH) : '0;
    assign bus.write_data_array = wr;
    assign bus.word_num         = wr ? rsp_cnt[WN_W-1:0] : '0;
    assign bus.fill_data        = wr ? bus.memory_data : '0;
    assign bus.write_tag_array  = last;
    assign bus.fsm_busy         = busy;
    assign bus.fill_done        = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_cnt <= '0;
            rsp_cnt <= '0;
            base    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (state == IDLE) begin
                if (bus.miss_detected) begin
                    base    <= bus.miss_address & ~OFF_MASK;
                    req_cnt <= '0;
                    rsp_cnt <= '0;
                    state   <= FILL;
                    busy    <= 1'b1;
                end
            end else begin
                req_cnt <= req_cnt + CW'(req);
                rsp_cnt <= rsp_cnt + CW'(wr);
                if (last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: scoreboard bench for the cache fill FSM
// Stimulus pushes expected requests, writes and done pulses (with their cycle) into
// queues; a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_cache_fill_fsm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   fill_k = 0;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic [2:0]  w;
        logic        tag;
    } exp_t;

    exp_t req_q[$];
    exp_t wr_q[$];
    int   done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8)) bus ();
    cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .BLK_WORDS(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   d;
        if (bus.memory_read_en) begin
            if (req_q.size() == 0) check("req_spurious", 32'(bus.memory_address), 32'hFFFF_FFFF);
            else begin
                e = req_q.pop_front();
                check("req_cyc", cyc, e.cyc);
                check("req_addr", 32'(bus.memory_address), 32'(e.val));
            end
        end
        if (bus.write_data_array) begin
            if (wr_q.size() == 0) check("wr_spurious", 32'(bus.word_num), 32'hFFFF_FFFF);
            else begin
                e = wr_q.pop_front();
                check("wr_cyc", cyc, e.cyc);
                check("wr_word", 32'(bus.word_num), 32'(e.w));
                check("wr_data", 32'(bus.fill_data), 32'(e.val));
                check("wr_tag", 32'(bus.write_tag_array), 32'(e.tag));
            end
        end else if (bus.write_tag_array) check("tag_alone", 1, 0);
        if (bus.fill_done) begin
            if (done_q.size() == 0) check("done_spurious", 1, 0);
            else begin
                d = done_q.pop_front();
                check("done_cyc", cyc, d);
            end
        end
    end

    task automatic check_reset_outs();
        check("rst_addr_data", {bus.memory_address, bus.fill_data}, 0);
        check("rst_ctl", {bus.memory_read_en, bus.write_data_array, bus.write_tag_array,
                          bus.word_num, bus.fsm_busy, bus.fill_done}, 0);
    endtask

    // Entered at #1 after a posedge (cycle 0 of the fill). pat bit n = return valid
    // in fill cycle n; stray = cycle of an extra miss pulse; abort = cycle where reset
    // is asserted; gap = idle cycles after the last return before returning.
    task automatic fill(input logic [15:0] a, input logic [31:0] pat, input int stray,
                        input int abort, input int gap);
        int   b;
        int   i;
        exp_t e;
        check("idle_busy", 32'(bus.fsm_busy), 0);
        b = cyc;
        fill_k++;
        bus.miss_detected = 1'b1;
        bus.miss_address  = a;
        for (int n = 1; n <= 8 && (abort == 0 || n < abort); n++) begin
            e.cyc = b + n;
            e.val = (a & 16'hFFF0) | 16'(2 * (n - 1));
            e.w   = '0;
            e.tag = 1'b0;
            req_q.push_back(e);
        end
        i = 0;
        for (int n = 1; n < 32 && i < 8; n++) begin
            @(posedge clk);
            #1;
            check("fill_busy", 32'(bus.fsm_busy), 1);
            if (n == abort) begin
                rst_n = 1'b0;
                bus.miss_detected     = 1'b0;
                bus.memory_data_valid = 1'b1;
                bus.memory_data       = 16'hFFFF;
                #1;
                check_reset_outs();
                repeat (2) @(posedge clk);
                #1;
                check_reset_outs();
                rst_n = 1'b1;
                bus.memory_data_valid = 1'b0;
                return;
            end
            bus.miss_detected     = (n == stray);
            bus.miss_address      = (n == stray) ? 16'hBEEF : a;
            bus.memory_data_valid = pat[n];
            bus.memory_data       = 16'hD000 | 16'(fill_k << 4) | 16'(i);
            if (pat[n]) begin
                e.cyc = cyc;
                e.val = bus.memory_data;
                e.w   = 3'(i);
                e.tag = (i == 7);
                wr_q.push_back(e);
                i++;
                if (i == 8) done_q.push_back(cyc + 1);
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            bus.memory_data_valid = 1'b0;
            bus.miss_detected     = 1'b0;
            if (g == 0) check("done_busy", {bus.fsm_busy, bus.fill_done}, 32'b01);
        end
    endtask

    initial begin
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.memory_data       = 16'h5A5A;
        bus.memory_data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs();
        rst_n = 1'b1;
        bus.memory_data_valid = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outs();
        fill(16'h1236, 32'h0000_1FE0, 0, 0, 2);
        fill(16'h1236, 32'h0000_1FE0, 3, 0, 2);
        bus.memory_data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.memory_data_valid = 1'b0;
        fill(16'h4A5C, 32'h0012_6648, 0, 0, 2);
        fill(16'h7770, 32'h0000_1FE0, 0, 7, 0);
        @(posedge clk);
        #1;
        fill(16'hFFF2, 32'h0000_1FE0, 0, 0, 2);
        fill(16'h2000, 32'h0000_03FC, 0, 0, 1);
        fill(16'h3008, 32'h0000_03FC, 0, 0, 1);
        fill(16'h5556, 32'h0000_1FE0, 0, 0, 2);
        repeat (4) @(posedge clk);
        #1;
        check("req_left", req_q.size(), 0);
        check("wr_left", wr_q.size(), 0);
        check("done_left", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
